// File: rtl/dig_scan_ctrl.sv
// Avalon-MM seven-segment scan controller: per-digit data registers multiplexed
// onto shared active-low segment and digit-select buses with a blanking interval.
module dig_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16,
  parameter int DIV_RESET    = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  dig,
  output logic [7:0]  seg
);

  localparam logic [3:0]  ADDR_CTRL  = 4'd0;
  localparam logic [3:0]  ADDR_DIV   = 4'd1;
  localparam logic [3:0]  ADDR_DATA0 = 4'd2;
  localparam logic [15:0] BLANK_W    = 16'(BLANK_CYCLES);
  localparam logic [15:0] DIV_INIT   = 16'(DIV_RESET);
  localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]  DIG_MASK   = 8'((1 << NUM_DIGITS) - 1);

  logic        en_q;
  logic        hex_q;
  logic [15:0] div_q;
  logic [7:0]  data_q [8];
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;

  logic        wr_en;
  logic [15:0] eff_div;
  logic        slot_end;
  logic [7:0]  cur_data;
  logic [7:0]  seg_on;
  logic [7:0]  dig_next;
  logic [7:0]  seg_next;
  logic        unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:16];

  // Standard gfedcba patterns, 1 = segment lit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Register file writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q  <= 1'b0;
      hex_q <= 1'b0;
      div_q <= DIV_INIT;
      // NOTE: the data registers are a handful of flops, not a RAM, so they take the async reset like everything else.
      for (int i = 0; i < 8; i++) data_q[i] <= 8'h00;
    end else if (wr_en) begin
      if (address == ADDR_CTRL) begin
        en_q  <= writedata[0];
        hex_q <= writedata[1];
      end
      if (address == ADDR_DIV) div_q <= writedata[15:0];
      for (int i = 0; i < 8; i++) begin
        if (address == ADDR_DATA0 + 4'(i)) data_q[i] <= writedata[7:0];
      end
    end
  end

  // A slot never shrinks below the blanking interval; a DIV lowered under the
  // running count lets cnt run out to 16'hFFFF before the slot closes.
  assign eff_div  = (div_q < BLANK_W) ? BLANK_W : div_q;
  assign slot_end = (cnt_q == eff_div) || (cnt_q == 16'hFFFF);

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'h0000;
      idx_q <= 3'd0;
    end else if (!en_q) begin
      cnt_q <= 16'h0000;
      idx_q <= 3'd0;
    end else if (slot_end) begin
      cnt_q <= 16'h0000;
      idx_q <= (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Next output pattern from the current scan state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cur_data = data_q[idx_q];
    seg_on   = cur_data;
    dig_next = 8'hFF;
    seg_next = 8'hFF;
    if (hex_q) seg_on = {cur_data[7], hex7(cur_data[3:0])};
    if (en_q && (cnt_q >= BLANK_W)) begin
      dig_next = ~((8'd1 << idx_q) & DIG_MASK);
      seg_next = ~seg_on;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      dig <= dig_next;
      seg <= seg_next;
    end
  end

  // Zero-wait-state read mux; unmapped addresses read 0.
  always_comb begin
    readdata = 32'h0000_0000;
    if (address == ADDR_CTRL) begin
      readdata = {21'b0, idx_q, 6'b0, hex_q, en_q};
    end else if (address == ADDR_DIV) begin
      readdata = {16'b0, div_q};
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (address == ADDR_DATA0 + 4'(i)) readdata = {24'b0, data_q[i]};
      end
    end
  end

endmodule
